// File: rtl/tage_pred_queue_pkg.sv
// Shared types for the TAGE prediction queue: predictor metadata and the
// per-entry record stored between fetch and commit.
package tage_pred_queue_pkg;

    localparam int PC_W = 32;

    typedef struct packed {
        logic [2:0]  provider;
        logic        provider_taken;
        logic        alt_taken;
        logic [2:0]  provider_ctr;
        logic [11:0] provider_tag;
    } TAGEPred;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        TAGEPred         info;
    } TAGEQEntry;

    localparam int ENTRY_W = $bits(TAGEQEntry);

    // A branch is mispredicted when the stored direction differs from the resolved one.
    function automatic logic is_mispred(input TAGEQEntry e, input logic resolved);
        return e.taken ^ resolved;
    endfunction

endpackage

// File: rtl/tage_pred_queue_if.sv
// Bundle of push, commit and status signals between the predictor/commit
// stages (master) and the prediction queue (slave).
interface tage_pred_queue_if #(
    parameter int DEPTH = 16
);
    import tage_pred_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    // Push side: a push transfers on a cycle where push_valid and push_ready
    // are both high and recover is low; push_ready never depends on push_valid.
    logic              recover;
    logic              push_valid;
    logic [PC_W-1:0]   push_pc;
    logic              push_taken;
    TAGEPred           push_info;
    logic              push_ready;

    logic              commit_in_valid;
    logic [PC_W-1:0]   commit_in_pc;
    logic              commit_in_taken;

    logic              commit_valid;
    logic [PC_W-1:0]   committed_pc;
    TAGEPred           committed_pred_info;
    logic              committed_branch_taken;
    logic              committed_mispred;

    logic [PTR_W:0]    count;
    logic              err_underflow;
    logic              err_pc_mismatch;

    modport master (
        output recover, push_valid, push_pc, push_taken, push_info,
        output commit_in_valid, commit_in_pc, commit_in_taken,
        input  push_ready,
        input  commit_valid, committed_pc, committed_pred_info,
        input  committed_branch_taken, committed_mispred,
        input  count, err_underflow, err_pc_mismatch
    );

    modport slave (
        input  recover, push_valid, push_pc, push_taken, push_info,
        input  commit_in_valid, commit_in_pc, commit_in_taken,
        output push_ready,
        output commit_valid, committed_pc, committed_pred_info,
        output committed_branch_taken, committed_mispred,
        output count, err_underflow, err_pc_mismatch
    );

endinterface

// File: rtl/tage_pred_queue_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port,
// contents deliberately left unreset.
module tage_pred_queue_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tage_pred_queue.sv
// FIFO of in-flight TAGE predictions; a commit pops the head and produces a
// registered TAGE update one cycle later, including the mispredict bit.
module tage_pred_queue
    import tage_pred_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    tage_pred_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    logic      full;
    logic      empty;
    logic      do_push;
    logic      do_pop;
    TAGEQEntry wr_entry;
    TAGEQEntry rd_entry;
    logic [ENTRY_W-1:0] rd_data;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // A same-cycle commit frees the head slot, so a full queue can still accept.
    assign bus.push_ready = !full || bus.commit_in_valid;
    assign do_push        = bus.push_valid && bus.push_ready && !bus.recover;
    assign do_pop         = bus.commit_in_valid && !empty;

    assign wr_entry.pc    = bus.push_pc;
    assign wr_entry.taken = bus.push_taken;
    assign wr_entry.info  = bus.push_info;
    assign rd_entry       = TAGEQEntry'(rd_data);

    tage_pred_queue_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_data)
    );

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Recover wins over pointer movement; the pop it may coincide with is
    // still reported through the commit registers below.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.recover) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.commit_valid           <= 1'b0;
            bus.committed_pc           <= '0;
            bus.committed_pred_info    <= '0;
            bus.committed_branch_taken <= 1'b0;
            bus.committed_mispred      <= 1'b0;
        end else begin
            bus.commit_valid <= do_pop;
            if (do_pop) begin
                bus.committed_pc           <= rd_entry.pc;
                bus.committed_pred_info    <= rd_entry.info;
                bus.committed_branch_taken <= bus.commit_in_taken;
                bus.committed_mispred      <= is_mispred(rd_entry, bus.commit_in_taken);
            end
        end
    end

    // Sticky error flags; a PC mismatch does not block the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err_underflow   <= 1'b0;
            bus.err_pc_mismatch <= 1'b0;
        end else begin
            if (bus.commit_in_valid && empty) begin
                bus.err_underflow <= 1'b1;
            end
            if (do_pop && (bus.commit_in_pc != rd_entry.pc)) begin
                bus.err_pc_mismatch <= 1'b1;
            end
        end
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_tage_pred_queue.sv
// Bench for tage_pred_queue: directed scenarios plus a randomized run, all
// checked against a queue-based reference model.
module tb_tage_pred_queue;
    import tage_pred_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tage_pred_queue_if #(.DEPTH(DEPTH)) bus ();

    tage_pred_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    TAGEQEntry   exp_q[$];
    logic        exp_cv;
    logic [31:0] exp_pc;
    TAGEPred     exp_info;
    logic        exp_bt;
    logic        exp_mp;
    logic        exp_uf;
    logic        exp_pm;
    logic        exp_ready;
    logic        obs_ready;

    int n_checks;
    int n_fail;

    task automatic set_idle();
        bus.recover         = 1'b0;
        bus.push_valid      = 1'b0;
        bus.push_pc         = '0;
        bus.push_taken      = 1'b0;
        bus.push_info       = '0;
        bus.commit_in_valid = 1'b0;
        bus.commit_in_pc    = '0;
        bus.commit_in_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        exp_q.delete();
        exp_cv   = 1'b0;
        exp_pc   = '0;
        exp_info = '0;
        exp_bt   = 1'b0;
        exp_mp   = 1'b0;
        exp_uf   = 1'b0;
        exp_pm   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
    task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                         input TAGEPred pi, input logic cv, input logic [31:0] cpc,
                         input logic ct, input logic rec);
        TAGEQEntry head_e;
        TAGEQEntry new_e;
        int        occ;
        bus.push_valid      = pv;
        bus.push_pc         = ppc;
        bus.push_taken      = pt;
        bus.push_info       = pi;
        bus.commit_in_valid = cv;
        bus.commit_in_pc    = cpc;
        bus.commit_in_taken = ct;
        bus.recover         = rec;
        #1;
        occ       = exp_q.size();
        exp_ready = (occ != DEPTH) || cv;
        obs_ready = bus.push_ready;
        exp_cv    = 1'b0;
        if (cv && occ == 0) exp_uf = 1'b1;
        if (cv && occ != 0) begin
            head_e   = exp_q.pop_front();
            exp_cv   = 1'b1;
            exp_pc   = head_e.pc;
            exp_info = head_e.info;
            exp_bt   = ct;
            exp_mp   = (head_e.taken != ct);
            if (cpc != head_e.pc) exp_pm = 1'b1;
        end
        if (rec) begin
            exp_q.delete();
        end else if (pv && exp_ready) begin
            new_e.pc    = ppc;
            new_e.taken = pt;
            new_e.info  = pi;
            exp_q.push_back(new_e);
        end
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic push_one(input logic [31:0] pc, input logic taken);
        drive(1'b1, pc, taken, TAGEPred'($urandom), 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic commit_one(input logic [31:0] pc, input logic taken);
        drive(1'b0, '0, 1'b0, '0, 1'b1, pc, taken, 1'b0);
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.push_ready); end
        n_checks++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %b want 0", bus.commit_valid); end
        n_checks++; if (bus.committed_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.committed_pc); end
        n_checks++; if (bus.committed_pred_info !== TAGEPred'(0)) begin n_fail++; $display("FAIL reset_info: got %h want 0", bus.committed_pred_info); end
        n_checks++; if (bus.committed_mispred !== 1'b0 || bus.committed_branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got mp=%b bt=%b want 0/0", bus.committed_mispred, bus.committed_branch_taken); end
        n_checks++; if (bus.err_underflow !== 1'b0 || bus.err_pc_mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_err: got uf=%b pm=%b want 0/0", bus.err_underflow, bus.err_pc_mismatch); end
    endtask

    task automatic test_basic();
        do_reset();
        push_one(32'h100, 1'b1);
        push_one(32'h104, 1'b0);
        push_one(32'h108, 1'b1);
        n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL basic_count3: got %0d want 3", bus.count); end
        commit_one(32'h100, 1'b1);
        n_checks++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL basic_cv1: got %b want 1", bus.commit_valid); end
        n_checks++; if (bus.committed_pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc1: got %h want 100", bus.committed_pc); end
        n_checks++; if (bus.committed_mispred !== 1'b0) begin n_fail++; $display("FAIL basic_mp1: got %b want 0", bus.committed_mispred); end
        n_checks++; if (bus.committed_pred_info !== exp_info) begin n_fail++; $display("FAIL basic_info1: got %h want %h", bus.committed_pred_info, exp_info); end
        n_checks++; if (bus.count !== CW'(2)) begin n_fail++; $display("FAIL basic_count2: got %0d want 2", bus.count); end
        commit_one(32'h104, 1'b1);
        n_checks++; if (bus.committed_pc !== 32'h104 || bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pc2: got %h cv=%b want 104 cv=1", bus.committed_pc, bus.commit_valid); end
        n_checks++; if (bus.committed_mispred !== 1'b1 || bus.committed_branch_taken !== 1'b1) begin n_fail++; $display("FAIL basic_mp2: got mp=%b bt=%b want 1/1", bus.committed_mispred, bus.committed_branch_taken); end
        idle_cycle();
        n_checks++; if (bus.commit_valid !== 1'b0 || bus.committed_pc !== 32'h104) begin n_fail++; $display("FAIL basic_hold: got cv=%b pc=%h want 0/104", bus.commit_valid, bus.committed_pc); end
    endtask

    task automatic test_full();
        logic [31:0] hp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one(32'h2000 + 32'(4 * i), 1'($urandom));
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", bus.count, DEPTH); end
        drive(1'b1, 32'hBAD0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", obs_ready); end
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_ignored: got %0d want %0d", bus.count, DEPTH); end
        hp = exp_q[0].pc;
        drive(1'b1, 32'h3000, 1'b1, TAGEPred'($urandom), 1'b1, hp, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_pop: got %b want 1", obs_ready); end
        n_checks++; if (bus.count !== CW'(DEPTH) || bus.committed_pc !== 32'h2000) begin n_fail++; $display("FAIL full_pushpop: got count=%0d pc=%h want %0d/2000", bus.count, bus.committed_pc, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            hp = exp_q[0].pc;
            commit_one(hp, 1'b1);
            n_checks++; if (bus.committed_pc !== exp_pc || bus.committed_mispred !== exp_mp) begin n_fail++; $display("FAIL full_drain%0d: got pc=%h mp=%b want %h/%b", i, bus.committed_pc, bus.committed_mispred, exp_pc, exp_mp); end
        end
        n_checks++; if (bus.committed_pc !== 32'h3000 || bus.count !== CW'(0)) begin n_fail++; $display("FAIL full_last: got pc=%h count=%0d want 3000/0", bus.committed_pc, bus.count); end
    endtask

    task automatic test_recover();
        do_reset();
        for (int i = 0; i < 5; i++) push_one(32'h400 + 32'(4 * i), 1'b0);
        drive(1'b1, 32'hDEAD0000, 1'b1, '0, 1'b1, 32'h400, 1'b1, 1'b1);
        n_checks++; if (bus.commit_valid !== 1'b1 || bus.committed_pc !== 32'h400) begin n_fail++; $display("FAIL recover_commit: got cv=%b pc=%h want 1/400", bus.commit_valid, bus.committed_pc); end
        n_checks++; if (bus.committed_mispred !== 1'b1) begin n_fail++; $display("FAIL recover_mp: got %b want 1", bus.committed_mispred); end
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL recover_count: got %0d want 0", bus.count); end
        push_one(32'h500, 1'b0);
        commit_one(32'h500, 1'b1);
        n_checks++; if (bus.committed_pc !== 32'h500 || bus.err_pc_mismatch !== 1'b0) begin n_fail++; $display("FAIL recover_dropped: got pc=%h pm=%b want 500/0", bus.committed_pc, bus.err_pc_mismatch); end
    endtask

    task automatic test_underflow();
        commit_one(32'h600, 1'b0);
        n_checks++; if (bus.commit_valid !== 1'b0 || bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow: got cv=%b uf=%b want 0/1", bus.commit_valid, bus.err_underflow); end
        n_checks++; if (bus.count !== CW'(0) || bus.committed_pc !== 32'h500) begin n_fail++; $display("FAIL underflow_state: got count=%0d pc=%h want 0/500", bus.count, bus.committed_pc); end
        push_one(32'h700, 1'b1);
        commit_one(32'h700, 1'b1);
        idle_cycle();
        n_checks++; if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", bus.err_underflow); end
        do_reset();
        n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", bus.err_underflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h800 + 32'(4 * i), 1'b1);
        bus.commit_in_valid = 1'b1;
        bus.commit_in_pc    = 32'h800;
        bus.push_valid      = 1'b1;
        bus.push_pc         = 32'h900;
        do_reset();
        n_checks++; if (bus.commit_valid !== 1'b0 || bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_mid: got cv=%b count=%0d want 0/0", bus.commit_valid, bus.count); end
        idle_cycle();
        n_checks++; if (bus.commit_valid !== 1'b0 || bus.push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_idle: got cv=%b ready=%b want 0/1", bus.commit_valid, bus.push_ready); end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            push_one(pc, 1'($urandom));
            commit_one(pc, 1'($urandom));
            n_checks++; if (bus.commit_valid !== 1'b1 || bus.committed_pc !== pc) begin n_fail++; $display("FAIL wrap%0d: got cv=%b pc=%h want 1/%h", i, bus.commit_valid, bus.committed_pc, pc); end
        end
        n_checks++; if (bus.err_pc_mismatch !== 1'b0 || bus.count !== CW'(0)) begin n_fail++; $display("FAIL wrap_clean: got pm=%b count=%0d want 0/0", bus.err_pc_mismatch, bus.count); end
        push_one(32'h1FC, 1'b1);
        commit_one(32'h200, 1'b1);
        n_checks++; if (bus.err_pc_mismatch !== 1'b1 || bus.commit_valid !== 1'b1 || bus.committed_pc !== 32'h1FC) begin n_fail++; $display("FAIL pc_mismatch: got pm=%b cv=%b pc=%h want 1/1/1fc", bus.err_pc_mismatch, bus.commit_valid, bus.committed_pc); end
        idle_cycle();
        n_checks++; if (bus.err_pc_mismatch !== 1'b1) begin n_fail++; $display("FAIL pc_mismatch_sticky: got %b want 1", bus.err_pc_mismatch); end
    endtask

    task automatic test_random();
        logic        pv, cv, rec, ct, pt;
        logic [31:0] cpc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pv  = ($urandom_range(99) < 60);
            cv  = ($urandom_range(99) < 45);
            rec = ($urandom_range(63) == 0);
            ct  = 1'($urandom);
            pt  = 1'($urandom);
            if (exp_q.size() != 0 && $urandom_range(15) != 0) cpc = exp_q[0].pc;
            else cpc = $urandom;
            drive(pv, $urandom, pt, TAGEPred'($urandom), cv, cpc, ct, rec);
            n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd%0d_ready: got %b want %b", i, obs_ready, exp_ready); end
            n_checks++; if (bus.commit_valid !== exp_cv) begin n_fail++; $display("FAIL rnd%0d_cv: got %b want %b", i, bus.commit_valid, exp_cv); end
            n_checks++; if (bus.committed_pc !== exp_pc || bus.committed_pred_info !== exp_info) begin n_fail++; $display("FAIL rnd%0d_entry: got %h/%h want %h/%h", i, bus.committed_pc, bus.committed_pred_info, exp_pc, exp_info); end
            n_checks++; if (bus.committed_branch_taken !== exp_bt || bus.committed_mispred !== exp_mp) begin n_fail++; $display("FAIL rnd%0d_dir: got bt=%b mp=%b want %b/%b", i, bus.committed_branch_taken, bus.committed_mispred, exp_bt, exp_mp); end
            n_checks++; if (bus.count !== CW'(exp_q.size())) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", i, bus.count, exp_q.size()); end
            n_checks++; if (bus.err_underflow !== exp_uf || bus.err_pc_mismatch !== exp_pm) begin n_fail++; $display("FAIL rnd%0d_err: got uf=%b pm=%b want %b/%b", i, bus.err_underflow, bus.err_pc_mismatch, exp_uf, exp_pm); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_idle();
        test_reset();
        test_basic();
        test_full();
        test_recover();
        test_underflow();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tage_pred_queue.md
Name: tage_pred_queue

Overview:
- FIFO of in-flight branch predictions between the TAGE predictor output (pred_taken/pred_info) and the commit stage.
- Each predicted branch pushes {pc, pred_taken, TAGEPred} at fetch; each committed branch pops the head and drives the TAGE update interface one cycle later, with committed_mispred computed here.
- A pipeline recover discards all uncommitted entries.

Parameters:
DEPTH, 16, number of entries; power of two, at least 2
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
recover  in  1  pipeline flush; discard all uncommitted entries
push_valid  in  1  predicted branch leaving the predictor
push_pc  in  32  branch PC
push_taken  in  1  predicted direction
push_info  in  TAGEPred  predictor metadata
push_ready  out  1  queue can accept a push this cycle
commit_in_valid  in  1  a branch commits this cycle
commit_in_pc  in  32  PC of the committing branch
commit_in_taken  in  1  resolved direction
commit_valid  out  1  TAGE update strobe
committed_pc  out  32  head PC
committed_pred_info  out  TAGEPred  head metadata
committed_branch_taken  out  1  resolved direction
committed_mispred  out  1  head predicted direction != resolved direction
count  out  PTR_W+1  occupancy
err_underflow  out  1  sticky: commit arrived while the queue was empty
err_pc_mismatch  out  1  sticky: commit_in_pc != head PC

Behaviour:
- Storage: DEPTH-entry array {pc, taken, info}. head/tail pointers are PTR_W bits and wrap modulo DEPTH. count is held separately; full when count == DEPTH, empty when count == 0.
- push_ready = (count != DEPTH) || commit_in_valid. Combinational; a pop frees a slot in the same cycle.
- Push accepted when push_valid && push_ready && !recover. Entry written at tail; tail += 1.
- Pop when commit_in_valid && count != 0. Head read and head += 1.
- Pop with count == 0: no state change, commit_valid stays 0, err_underflow set.
- Commit output registered; 1-cycle latency. On the cycle after a pop:
  - commit_valid = 1
  - committed_pc, committed_pred_info = head entry
  - committed_branch_taken = commit_in_taken
  - committed_mispred = head.taken ^ commit_in_taken
  - All commit outputs are held when commit_valid is 0.
- PC mismatch on pop: err_pc_mismatch set. The pop and update still proceed (no resync).
- Simultaneous push and pop: count unchanged. This is legal when full and when count == 1. Read-before-write on the same slot is impossible because the pointers differ unless count is 0 or DEPTH.
- recover:
  - Any same-cycle pop is processed first, so the committing branch still updates TAGE.
  - Then head = tail = 0 and count = 0.
  - A same-cycle push is dropped.
- Reset values: head, tail, count = 0; commit_valid, committed_* and both error flags = 0. push_ready = 1 after reset. Array contents are not reset.
- Reset mid-operation discards all entries. No commit strobe is emitted in the cycle after a reset.
- Error flags clear only on rst.

Decomposition:
- Shared package: TAGEPred typedef (already defined) and a new TAGEQEntry struct {pc, taken, info}.
- One sub-module, tage_pred_queue_ram: DEPTH x $bits(TAGEQEntry), 1 write port, 1 asynchronous read port, no reset.
- Pointer, count and commit-register logic stays in the top.

Test Plan:
- After rst, push 3 entries (pc 0x100/0x104/0x108, taken 1/0/1), then commit 0x100 with taken=1 -> next cycle commit_valid=1, committed_pc=0x100, committed_mispred=0, count=2.
- Commit 0x104 with taken=1 -> committed_mispred=1, committed_branch_taken=1.
- Fill 16 entries -> push_ready=0 and a push with commit_in_valid low is ignored. Then push and commit in the same cycle -> count stays 16, and the new entry is popped 16th later with the correct pc.
- Push 5 entries; in one cycle assert recover, commit_in_valid and push_valid -> next cycle commit_valid=1 for the head, count=0, the pushed entry is not stored.
- Commit while empty -> commit_valid=0, err_underflow=1 and stays 1 until rst.
- Wrap-around: 40 alternating push/pop pairs with DEPTH=16 -> every popped pc equals its pushed pc in FIFO order. Commit pc 0x200 when the head is 0x1FC -> err_pc_mismatch=1.
